// File: rtl/iir_sos_cascade_if.sv
// Sample stream handshake for iir_sos_cascade.
// The master feeds samples and takes results; the filter is the slave.
interface iir_sos_cascade_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/iir_sos_cascade.sv
// Cascade of TDF-II biquads sharing one multiply/accumulate datapath.
// Define IIR_CASC_SAT_CNT_EN to add the sat_cnt saturation counter output.
module iir_sos_cascade #(
    parameter int DATA_W  = 24,
    parameter int COEF_W  = 24,
    parameter int FRAC_W  = 22,
    parameter int NUM_SEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    iir_sos_cascade_if.slave  strm,
    input  logic              coef_we,
    input  logic [3:0]        coef_sec,
    input  logic [2:0]        coef_sel,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              clear_state
`ifdef IIR_CASC_SAT_CNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);
    localparam int PW  = DATA_W + COEF_W;
    localparam int AW  = PW + 3;
    localparam int SW  = DATA_W + FRAC_W + 1;
    localparam int SCW = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

    localparam logic signed [COEF_W-1:0] UNITY =
        COEF_W'(1) << FRAC_W;
    localparam logic signed [AW:0] HALF =
        (AW+1)'(1) << (FRAC_W - 1);
    localparam logic signed [AW:0] YMAX =
        {{(AW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW:0] YMIN = ~YMAX;
    localparam logic signed [AW-1:0] SMAX =
        {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [COEF_W-1:0] b0 [NUM_SEC];
    logic signed [COEF_W-1:0] b1 [NUM_SEC];
    logic signed [COEF_W-1:0] b2 [NUM_SEC];
    logic signed [COEF_W-1:0] a1 [NUM_SEC];
    logic signed [COEF_W-1:0] a2 [NUM_SEC];
    logic signed [SW-1:0]     s1 [NUM_SEC];
    logic signed [SW-1:0]     s2 [NUM_SEC];

    logic [SCW-1:0]           sec_cnt;
    logic signed [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0]        out_reg;
    logic                     idle;
    logic                     accept;
    logic                     last;

    assign idle   = (state == IDLE);
    assign last   = (sec_cnt == SCW'(NUM_SEC - 1));
    // clear_state blocks acceptance so a clear never races a new sample
    assign accept = idle && strm.in_valid && !clear_state;

    assign strm.in_ready  = idle && !clear_state;
    assign strm.out_valid = (state == DONE);
    assign strm.out_data  = out_reg;

    logic signed [COEF_W-1:0] cb0, cb1, cb2, ca1, ca2;
    logic signed [SW-1:0]     cs1, cs2;

    always_comb begin
        cb0 = '0;
        cb1 = '0;
        cb2 = '0;
        ca1 = '0;
        ca2 = '0;
        cs1 = '0;
        cs2 = '0;
        for (int i = 0; i < NUM_SEC; i++) begin
            if (sec_cnt == SCW'(i)) begin
                cb0 = b0[i];
                cb1 = b1[i];
                cb2 = b2[i];
                ca1 = a1[i];
                ca2 = a2[i];
                cs1 = s1[i];
                cs2 = s2[i];
            end
        end
    end

    logic signed [PW-1:0]     p_b0, p_b1, p_b2;
    logic signed [PW-1:0]     p_a1, p_a2;
    logic signed [AW-1:0]     acc_y, acc1, acc2;
    logic signed [AW:0]       y_full;
    logic signed [DATA_W-1:0] y;
    logic signed [SW-1:0]     s1_nx, s2_nx;

    assign p_b0 = PW'(cb0) * PW'(x_reg);
    assign p_b1 = PW'(cb1) * PW'(x_reg);
    assign p_b2 = PW'(cb2) * PW'(x_reg);
    assign p_a1 = PW'(ca1) * PW'(y);
    assign p_a2 = PW'(ca2) * PW'(y);

    assign acc_y  = AW'(p_b0) + AW'(cs1);
    assign y_full = ((AW+1)'(acc_y) + HALF) >>> FRAC_W;
    assign acc1   = AW'(p_b1) - AW'(p_a1) + AW'(cs2);
    assign acc2   = AW'(p_b2) - AW'(p_a2);

    always_comb begin
        y = y_full[DATA_W-1:0];
        if (y_full > YMAX) begin
            y = YMAX[DATA_W-1:0];
        end else if (y_full < YMIN) begin
            y = YMIN[DATA_W-1:0];
        end
    end

    always_comb begin
        s1_nx = acc1[SW-1:0];
        if (acc1 > SMAX) begin
            s1_nx = SMAX[SW-1:0];
        end else if (acc1 < SMIN) begin
            s1_nx = SMIN[SW-1:0];
        end
    end

    always_comb begin
        s2_nx = acc2[SW-1:0];
        if (acc2 > SMAX) begin
            s2_nx = SMAX[SW-1:0];
        end else if (acc2 < SMIN) begin
            s2_nx = SMIN[SW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (strm.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt <= '0;
            x_reg   <= '0;
            out_reg <= '0;
            for (int i = 0; i < NUM_SEC; i++) begin
                b0[i] <= UNITY;
                b1[i] <= '0;
                b2[i] <= '0;
                a1[i] <= '0;
                a2[i] <= '0;
                s1[i] <= '0;
                s2[i] <= '0;
            end
        end else begin
            // writes land on the accept edge, so that sample sees them
            if (idle && coef_we) begin
                for (int i = 0; i < NUM_SEC; i++) begin
                    if (coef_sec == 4'(i)) begin
                        case (coef_sel)
                            3'd0:    b0[i] <= coef_wdata;
                            3'd1:    b1[i] <= coef_wdata;
                            3'd2:    b2[i] <= coef_wdata;
                            3'd3:    a1[i] <= coef_wdata;
                            3'd4:    a2[i] <= coef_wdata;
                            default: ;
                        endcase
                    end
                end
            end
            if (idle && clear_state) begin
                for (int i = 0; i < NUM_SEC; i++) begin
                    s1[i] <= '0;
                    s2[i] <= '0;
                end
            end
            if (accept) begin
                x_reg   <= strm.in_data;
                sec_cnt <= '0;
            end
            if (state == BUSY) begin
                for (int i = 0; i < NUM_SEC; i++) begin
                    if (sec_cnt == SCW'(i)) begin
                        s1[i] <= s1_nx;
                        s2[i] <= s2_nx;
                    end
                end
                x_reg   <= y;
                sec_cnt <= sec_cnt + SCW'(1);
                if (last) begin
                    out_reg <= y;
                end
            end
        end
    end

`ifdef IIR_CASC_SAT_CNT_EN
    logic sat_hit;

    assign sat_hit = (y_full > YMAX) || (y_full < YMIN) ||
                     (acc1 > SMAX) || (acc1 < SMIN) ||
                     (acc2 > SMAX) || (acc2 < SMIN);

    always_ff @(posedge clk) begin
        if (rst || (idle && clear_state)) begin
            sat_cnt <= '0;
        end else if (state == BUSY && sat_hit &&
                     sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_iir_sos_cascade.sv
// Self-checking bench for iir_sos_cascade with two sections.
// Samples are scored through an expected-result queue.
module tb_iir_sos_cascade;
    localparam int DATA_W  = 24;
    localparam int COEF_W  = 24;
    localparam int FRAC_W  = 22;
    localparam int NUM_SEC = 2;

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_sec = '0;
    logic [2:0]        coef_sel = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              clear_state = 1'b0;
`ifdef IIR_CASC_SAT_CNT_EN
    logic [15:0]       sat_cnt;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t e;
    logic prev_v = 1'b0;

    iir_sos_cascade_if #(.DATA_W(DATA_W)) bus ();

    iir_sos_cascade #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .FRAC_W  (FRAC_W),
        .NUM_SEC (NUM_SEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .strm        (bus),
        .coef_we     (coef_we),
        .coef_sec    (coef_sec),
        .coef_sel    (coef_sel),
        .coef_wdata  (coef_wdata),
        .clear_state (clear_state)
`ifdef IIR_CASC_SAT_CNT_EN
        ,
        .sat_cnt     (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: latency on each rising out_valid, data on each transfer
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(bus.out_valid), 0);
                end else begin
                    check("latency", cyc - exp_q[0].cyc, NUM_SEC);
                end
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("idle_timeout", 32'(bus.in_ready), 1);
    endtask

    task automatic send(input logic [DATA_W-1:0] din,
                        input logic [DATA_W-1:0] dexp, input bit push);
        wait_idle();
        bus.in_data  = din;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) exp_q.push_back('{dexp, cyc});
    endtask

    task automatic write_coef(input logic [3:0] sec, input logic [2:0] sel,
                              input logic [COEF_W-1:0] val);
        wait_idle();
        coef_sec   = sec;
        coef_sel   = sel;
        coef_wdata = val;
        coef_we    = 1'b1;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t unity_tab[6];
        vec_t impulse_tab[4];
        int n;

        unity_tab[0] = '{24'h123456, 24'h123456};
        unity_tab[1] = '{24'h000000, 24'h000000};
        unity_tab[2] = '{24'h7FFFFF, 24'h7FFFFF};
        unity_tab[3] = '{24'h800000, 24'h800000};
        unity_tab[4] = '{24'hFFFFFF, 24'hFFFFFF};
        unity_tab[5] = '{24'h000001, 24'h000001};
        impulse_tab[0] = '{24'd1000, 24'd1000};
        impulse_tab[1] = '{24'd0,    24'd500};
        impulse_tab[2] = '{24'd0,    24'd250};
        impulse_tab[3] = '{24'd0,    24'd125};

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
`ifdef IIR_CASC_SAT_CNT_EN
        check("rst_sat_cnt", 32'(sat_cnt), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            send(unity_tab[i].din, unity_tab[i].dout, 1'b1);
        end
        drain();

        write_coef(4'd0, 3'd0, 24'h600000);
        send(24'h7FFFFF, 24'h7FFFFF, 1'b1);
        drain();
`ifdef IIR_CASC_SAT_CNT_EN
        check("sat_cnt_pos", 32'(sat_cnt), 1);
`endif
        send(24'h800000, 24'h800000, 1'b1);
        drain();
`ifdef IIR_CASC_SAT_CNT_EN
        check("sat_cnt_neg", 32'(sat_cnt), 2);
`endif
        write_coef(4'd0, 3'd0, 24'h400000);

        // Hold in DONE with out_ready low; a coef write there is dropped
        bus.out_ready = 1'b0;
        send(24'h000200, 24'h000200, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach_done", 32'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                coef_sec   = 4'd0;
                coef_sel   = 3'd0;
                coef_wdata = 24'h200000;
                coef_we    = 1'b1;
            end
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_out_data", 32'(bus.out_data), 32'h200);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
            coef_we = 1'b0;
        end
        bus.out_ready = 1'b1;
        drain();
        send(24'h000300, 24'h000300, 1'b1);
        drain();

        write_coef(4'd0, 3'd3, 24'hE00000);
        for (int i = 0; i < 4; i++) begin
            send(impulse_tab[i].din, impulse_tab[i].dout, 1'b1);
        end
        drain();

        // clear_state together with in_valid: only the clear happens
        wait_idle();
        clear_state  = 1'b1;
        bus.in_data  = 24'h000555;
        bus.in_valid = 1'b1;
        @(negedge clk);
        clear_state  = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("clr_no_out_valid", 32'(bus.out_valid), 0);
        end
        check("clr_in_ready", 32'(bus.in_ready), 1);
        send(24'h000000, 24'h000000, 1'b1);
        drain();

        // Coef write and sample in the same cycle
        wait_idle();
        coef_sec     = 4'd0;
        coef_sel     = 3'd0;
        coef_wdata   = 24'h200000;
        coef_we      = 1'b1;
        bus.in_data  = 24'h000400;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{24'h000200, cyc});
        coef_we      = 1'b0;
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-flight: no result, states and coefs back to reset
        send(24'h001000, 24'h000000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_out_valid", 32'(bus.out_valid), 0);
        end
        check("abort_in_ready", 32'(bus.in_ready), 1);
        check("abort_out_data", 32'(bus.out_data), 0);
`ifdef IIR_CASC_SAT_CNT_EN
        check("abort_sat_cnt", 32'(sat_cnt), 0);
`endif
        send(24'h000100, 24'h000100, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
